sincos_sched: RTL and testbench
===============================

Name: sincos_sched

Overview:
- Round-robin scheduler that shares one sine/cosine evaluation unit among NREQ requesters.
- Accepts IEEE-754 single-precision operands plus a function select (sin/cos) from each requester.
- Issues one job at a time to the unit with a start pulse and waits for its done strobe.
- Returns the 32-bit result, tagged with the requester id; sits between the FP instruction front-end and the trig datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester id width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with SINCOS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request; held high until the matching req_ready
- req_opx  in  NREQ*32  per-requester operand (float32 bits), slice i = [32*i+31:32*i]
- req_func  in  NREQ  per-requester select: 0 = sin, 1 = cos
- req_ready  out  NREQ  one-hot, one-cycle acceptance pulse
- resp_valid  out  1  one-cycle result strobe
- resp_id  out  IDW  requester id of the result
- resp_data  out  32  result bits
- resp_err  out  1  result came from a watchdog abort
- unit_start  out  1  one-cycle start to the trig unit
- unit_opx  out  32  operand to the unit, stable from ISSUE until the job retires
- unit_func  out  1  function select to the unit
- unit_result  in  32  unit result, valid when unit_done=1
- unit_done  in  1  unit completion strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset values (next edge with rst=1): state=IDLE; rr_ptr=0; all outputs 0, including unit_opx, resp_data and resp_id.
- Reset mid-job drops the job; no response is produced. The unit's own reset is the integrator's concern.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - If a winner exists, on the edge: latch opx/func/id into unit_opx/unit_func/cur_id, register req_ready[winner]=1 for the next cycle, and go to ISSUE.
  - If no request is pending, stay in IDLE.
- ISSUE: unit_start=1 and req_ready[cur_id]=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Sample unit_done only in this state; a done in ISSUE is ignored (the unit guarantees done ≥1 cycle after start).
  - On unit_done=1: latch unit_result into resp_data, set resp_err=0, go to RESP.
- RESP:
  - resp_valid=1 and resp_id=cur_id for one cycle; set rr_ptr=(cur_id+1) mod NREQ; go to IDLE.
  - resp_data and resp_id hold until the next response.
- Latency:
  - Request seen in IDLE at edge T → req_ready and unit_start at cycle T+1.
  - unit_done at cycle D → resp_valid at D+1.
  - Minimum idle-to-idle turnaround: 4 cycles when done arrives the cycle after start.
- Fairness: a requester that is continuously valid is served within NREQ jobs. Simultaneous requests resolve by rr_ptr order.
- req_valid dropped before acceptance: treated as withdrawn; no error.
- Operands are not range-checked here; the datapath owns range reduction.
- A spurious unit_done outside WAIT is ignored.

Optional Feature:
- Macro: SINCOS_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without unit_done, go to RESP with resp_data=32'h7FC00000 (quiet NaN) and resp_err=1.
  - A unit_done arriving in that same cycle wins, giving a normal result.
- When undefined: WAIT waits indefinitely, no counter is built, and resp_err is tied to 0.

Decomposition:
- Package sincos_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
  - localparam FUNC_SIN=1'b0, FUNC_COS=1'b1;
  - localparam FP32_QNAN=32'h7FC00000.
- One sub-module, rr_arbiter: inputs req[NREQ] and ptr; outputs combinational one-hot grant and grant_id.
- The FSM, latches and watchdog remain in sincos_sched.

Test Plan:
- Reset with req_valid=4'b1111 held → no req_ready, unit_start, resp_valid or busy during or after reset until the first edge with rst=0.
- Single request: req_valid[2]=1, opx=32'h3FC90FDB (pi/2), func=0; unit returns 32'h3F800000 three cycles after start → req_ready=4'b0100 and unit_start in the same cycle; resp_valid one cycle after done with resp_id=2, resp_data=32'h3F800000.
- All four requesters valid from reset release; unit done one cycle after each start → grant order 0,1,2,3,0; each response carries the matching id and echoed func.
- Requester 1 continuously valid, requester 3 asserts mid-job for 1 → next grant goes to 3 before 1 repeats.
- unit_done pulsed during ISSUE and during IDLE → ignored; the response appears only after a done in WAIT.
- With SINCOS_TIMEOUT_EN and TIMEOUT_CYCLES=8, unit never completes → resp_valid 8 cycles after entering WAIT with resp_data=32'h7FC00000 and resp_err=1; the next request is then served normally with resp_err=0.

Source files
------------

// File: rtl/sincos_pkg.sv
// Shared types and constants for the sin/cos request scheduler.
package sincos_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;

   localparam logic        FUNC_SIN  = 1'b0;
   localparam logic        FUNC_COS  = 1'b1;
   localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

endpackage

// File: rtl/sincos_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo NREQ.
module rr_arbiter
   import sincos_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   logic           found;
   logic [IDW-1:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/sincos_sched.sv
// sincos_sched: shares one sin/cos evaluation unit among NREQ requesters, one job at a time.
// Define SINCOS_TIMEOUT_EN to build a watchdog that aborts a stuck job with a quiet-NaN result.
module sincos_sched
   import sincos_pkg::*;
#(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned IDW            = $clog2(NREQ),
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*32-1:0] req_opx,
   input  logic [NREQ-1:0]   req_func,
   output logic [NREQ-1:0]   req_ready,
   output logic              resp_valid,
   output logic [IDW-1:0]    resp_id,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              unit_start,
   output logic [31:0]       unit_opx,
   output logic              unit_func,
   input  logic [31:0]       unit_result,
   input  logic              unit_done,
   output logic              busy
);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("sincos_sched: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
   end

   sched_state_t    state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  cur_id_q, cur_id_d;
   logic [IDW-1:0]  resp_id_q, resp_id_d;
   logic [31:0]     unit_opx_q, unit_opx_d;
   logic            unit_func_q, unit_func_d;
   logic [31:0]     resp_data_q, resp_data_d;
   logic [NREQ-1:0] req_ready_q, req_ready_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;

`ifdef SINCOS_TIMEOUT_EN
   localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES);
   logic [CNTW-1:0] wd_cnt_q, wd_cnt_d;
   logic            resp_err_q, resp_err_d;
   logic            wd_expired;

   assign wd_expired = (wd_cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
`endif

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr_q),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         cur_id_q    <= '0;
         resp_id_q   <= '0;
         unit_opx_q  <= '0;
         unit_func_q <= FUNC_SIN;
         resp_data_q <= '0;
         req_ready_q <= '0;
`ifdef SINCOS_TIMEOUT_EN
         wd_cnt_q    <= '0;
         resp_err_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cur_id_q    <= cur_id_d;
         resp_id_q   <= resp_id_d;
         unit_opx_q  <= unit_opx_d;
         unit_func_q <= unit_func_d;
         resp_data_q <= resp_data_d;
         req_ready_q <= req_ready_d;
`ifdef SINCOS_TIMEOUT_EN
         wd_cnt_q    <= wd_cnt_d;
         resp_err_q  <= resp_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cur_id_d    = cur_id_q;
      resp_id_d   = resp_id_q;
      unit_opx_d  = unit_opx_q;
      unit_func_d = unit_func_q;
      resp_data_d = resp_data_q;
      req_ready_d = '0;
`ifdef SINCOS_TIMEOUT_EN
      wd_cnt_d    = wd_cnt_q;
      resp_err_d  = resp_err_q;
`endif
      unique case (state_q)
         IDLE: begin
            // The acceptance pulse is registered here so it lines up with unit_start in ISSUE.
            if (|req_valid) begin
               state_d     = ISSUE;
               cur_id_d    = grant_id;
               unit_opx_d  = req_opx[32*grant_id +: 32];
               unit_func_d = req_func[grant_id];
               req_ready_d = grant;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef SINCOS_TIMEOUT_EN
            wd_cnt_d = '0;
`endif
         end
         WAIT: begin
            if (unit_done) begin
               state_d     = RESP;
               resp_data_d = unit_result;
               resp_id_d   = cur_id_q;
`ifdef SINCOS_TIMEOUT_EN
               resp_err_d  = 1'b0;
            end else if (wd_expired) begin
               state_d     = RESP;
               resp_data_d = FP32_QNAN;
               resp_id_d   = cur_id_q;
               resp_err_d  = 1'b1;
            end else begin
               wd_cnt_d    = wd_cnt_q + 1'b1;
`endif
            end
         end
         RESP: begin
            state_d  = IDLE;
            rr_ptr_d = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      unit_start = (state_q == ISSUE);
      resp_valid = (state_q == RESP);
      busy       = (state_q != IDLE);
   end

   assign req_ready = req_ready_q;
   assign unit_opx  = unit_opx_q;
   assign unit_func = unit_func_q;
   assign resp_id   = resp_id_q;
   assign resp_data = resp_data_q;
`ifdef SINCOS_TIMEOUT_EN
   assign resp_err  = resp_err_q;
`else
   assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sincos_sched.sv
// Scoreboard bench for sincos_sched: directed requests, a behavioural trig unit, and a decoupled monitor.
module tb_sincos_sched;
   import sincos_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
`ifdef SINCOS_TIMEOUT_EN
   localparam int unsigned TO_CYC = 8;
`else
   localparam int unsigned TO_CYC = 64;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*32-1:0]  req_opx = '0;
   logic [NREQ-1:0]     req_func = '0;
   logic [NREQ-1:0]     req_ready;
   logic                resp_valid;
   logic [IDW-1:0]      resp_id;
   logic [31:0]         resp_data;
   logic                resp_err;
   logic                unit_start;
   logic [31:0]         unit_opx;
   logic                unit_func;
   logic [31:0]         unit_result = '0;
   logic                unit_done = 1'b0;
   logic                busy;

   always #5 clk = ~clk;

   sincos_sched #(
      .NREQ           (NREQ),
      .IDW            (IDW),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_opx     (req_opx),
      .req_func    (req_func),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_id     (resp_id),
      .resp_data   (resp_data),
      .resp_err    (resp_err),
      .unit_start  (unit_start),
      .unit_opx    (unit_opx),
      .unit_func   (unit_func),
      .unit_result (unit_result),
      .unit_done   (unit_done),
      .busy        (busy)
   );

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    opx;
      logic           func;
   } grant_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      logic           err;
   } resp_t;

   grant_t grant_q[$];
   resp_t  resp_q[$];
   int     checks = 0;
   int     errors = 0;

   // Stand-in for the trig datapath: pi/2 sine is exact, anything else echoes operand and func.
   function automatic logic [31:0] trig_model(input logic [31:0] x, input logic f);
      if (x == 32'h3FC90FDB && f == FUNC_SIN) return 32'h3F800000;
      return {x[30:0], f};
   endfunction

   task automatic expect_job(input int id, input logic [31:0] opx, input logic func,
                             input logic [31:0] data, input logic err);
      grant_t g;
      resp_t  r;
      g.id = IDW'(id); g.opx = opx; g.func = func;
      r.id = IDW'(id); r.data = data; r.err = err;
      grant_q.push_back(g);
      resp_q.push_back(r);
   endtask

   // Behavioural unit: done unit_lat cycles after start (0 = never), plus optional stray strobes.
   int          unit_lat = 1;
   bit          stray_issue = 1'b0;
   int          stray_idle_req = 0;
   int          stray_idle_done = 0;
   int          unit_cnt = 0;
   logic [31:0] unit_pend = '0;

   initial forever begin
      @(posedge clk);
      #1;
      unit_done = 1'b0;
      if (unit_cnt > 0) begin
         unit_cnt--;
         if (unit_cnt == 0) begin
            unit_done   = 1'b1;
            unit_result = unit_pend;
         end
      end
      if (unit_start) begin
         unit_pend = trig_model(unit_opx, unit_func);
         unit_cnt  = unit_lat;
         if (stray_issue) begin
            unit_done   = 1'b1;
            unit_result = 32'hDEADBEEF;
         end
      end else if (stray_idle_req != stray_idle_done && !busy && !rst) begin
         stray_idle_done++;
         unit_done   = 1'b1;
         unit_result = 32'hDEADBEEF;
      end
   end

   // Monitor: every grant and every response is matched against the scoreboard queues.
   logic   prev_done = 1'b0;
   grant_t mg;
   resp_t  mr;

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (req_ready != '0 || unit_start) begin
            checks++;
            if (grant_q.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected: req_ready=%b unit_start=%b, required no grant", req_ready, unit_start);
            end else begin
               mg = grant_q.pop_front();
               if (req_ready !== (NREQ'(1) << mg.id) || unit_start !== 1'b1 ||
                   unit_opx !== mg.opx || unit_func !== mg.func) begin
                  errors++;
                  $display("FAIL grant: req_ready=%b start=%b opx=%h func=%b, required id=%0d start=1 opx=%h func=%b",
                           req_ready, unit_start, unit_opx, unit_func, mg.id, mg.opx, mg.func);
               end
            end
         end
         if (resp_valid) begin
            checks++;
            if (resp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: id=%0d data=%h err=%b, required no response", resp_id, resp_data, resp_err);
            end else begin
               mr = resp_q.pop_front();
               if (resp_id !== mr.id || resp_data !== mr.data || resp_err !== mr.err) begin
                  errors++;
                  $display("FAIL resp: id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                           resp_id, resp_data, resp_err, mr.id, mr.data, mr.err);
               end
            end
            if (!mr.err) begin
               checks++;
               if (!prev_done) begin
                  errors++;
                  $display("FAIL resp_latency: resp_valid=1 with done_prev_cycle=%b, required 1", prev_done);
               end
            end
         end
      end
      prev_done = unit_done;
   end

   task automatic do_req(input int id, input logic [31:0] opx, input logic func, input int nrep);
      bit got;
      for (int r = 0; r < nrep; r++) begin
         req_opx[32*id +: 32] = opx + 32'(r);
         req_func[id]         = func;
         req_valid[id]        = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
         end
         if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: id=%0d req_ready=%b, required acceptance within 300 cycles", id, req_ready);
         end
         @(posedge clk);
         #1;
      end
      req_valid[id] = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (resp_q.size() == 0 && grant_q.size() == 0 && !busy) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: grants_left=%0d resps_left=%0d busy=%b, required 0 0 0",
                  grant_q.size(), resp_q.size(), busy);
         grant_q.delete();
         resp_q.delete();
      end
   endtask

   localparam logic [31:0] OP0 = 32'h40490FDB;
   localparam logic [31:0] OP1 = 32'h3F000000;
   localparam logic [31:0] OP2 = 32'hBF800000;
   localparam logic [31:0] OP3 = 32'h41200000;
   localparam logic [31:0] OPA = 32'h3E800000;
   localparam logic [31:0] OPB = 32'hC0000000;
   localparam logic [31:0] OPC = 32'h42F60000;

   initial begin
      // All four requesters valid through reset; service order 0,1,2,3,0.
      unit_lat = 1;
      expect_job(0, OP0, 1'b0, trig_model(OP0, 1'b0), 1'b0);
      expect_job(1, OP1, 1'b1, trig_model(OP1, 1'b1), 1'b0);
      expect_job(2, OP2, 1'b0, trig_model(OP2, 1'b0), 1'b0);
      expect_job(3, OP3, 1'b1, trig_model(OP3, 1'b1), 1'b0);
      expect_job(0, OP0 + 32'd1, 1'b0, trig_model(OP0 + 32'd1, 1'b0), 1'b0);
      fork
         begin
            repeat (3) begin
               @(negedge clk);
               checks++;
               if (req_ready !== '0 || unit_start !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 ||
                   unit_opx !== '0 || resp_data !== '0 || resp_id !== '0 || resp_err !== 1'b0) begin
                  errors++;
                  $display("FAIL reset: ready=%b start=%b rv=%b busy=%b opx=%h data=%h id=%0d err=%b, required all 0",
                           req_ready, unit_start, resp_valid, busy, unit_opx, resp_data, resp_id, resp_err);
               end
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || unit_start !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL reset_release: ready=%b start=%b busy=%b, required 0 0 0 before first active edge",
                        req_ready, unit_start, busy);
            end
         end
         do_req(0, OP0, 1'b0, 2);
         do_req(1, OP1, 1'b1, 1);
         do_req(2, OP2, 1'b0, 1);
         do_req(3, OP3, 1'b1, 1);
      join
      drain();

      // Single pi/2 sine on requester 2 with a three-cycle unit.
      unit_lat = 3;
      expect_job(2, 32'h3FC90FDB, FUNC_SIN, 32'h3F800000, 1'b0);
      do_req(2, 32'h3FC90FDB, FUNC_SIN, 1);
      drain();

      // Requester 1 stays valid; requester 3 joins mid-job and must be served before 1 repeats.
      unit_lat = 4;
      expect_job(1, OPA, 1'b0, trig_model(OPA, 1'b0), 1'b0);
      expect_job(3, OPB, 1'b1, trig_model(OPB, 1'b1), 1'b0);
      expect_job(1, OPA + 32'd1, 1'b0, trig_model(OPA + 32'd1, 1'b0), 1'b0);
      fork
         do_req(1, OPA, 1'b0, 2);
         begin
            repeat (2) @(posedge clk);
            #1;
            do_req(3, OPB, 1'b1, 1);
         end
      join
      drain();

      // Stray done strobes in IDLE and in ISSUE must be ignored.
      stray_idle_req++;
      repeat (3) @(negedge clk);
      stray_issue = 1'b1;
      unit_lat    = 3;
      expect_job(0, OPC, FUNC_COS, trig_model(OPC, FUNC_COS), 1'b0);
      do_req(0, OPC, FUNC_COS, 1);
      drain();
      stray_issue = 1'b0;

`ifdef SINCOS_TIMEOUT_EN
      // Unit never completes: watchdog aborts after TO_CYC WAIT cycles, then service resumes normally.
      begin
         int lat;
         unit_lat = 0;
         lat = -1;
         expect_job(2, OP2, 1'b0, FP32_QNAN, 1'b1);
         do_req(2, OP2, 1'b0, 1);
         for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (resp_valid) lat = k - 1;
         end
         checks++;
         if (lat != int'(TO_CYC)) begin
            errors++;
            $display("FAIL timeout_latency: resp after %0d WAIT cycles, required %0d", lat, TO_CYC);
         end
         unit_cnt = 0;
         unit_lat = 1;
         expect_job(3, OP3, 1'b1, trig_model(OP3, 1'b1), 1'b0);
         do_req(3, OP3, 1'b1, 1);
         drain();
      end
`endif

      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required finish before 200000 time units");
      $fatal(1, "global timeout");
   end

endmodule
